mips_multicycle_ctrl: RTL
=========================

// Module: mips_multicycle_ctrl
// PURPOSE
// Multicycle control FSM for the 32-bit MIPS datapath: sequences fetch, decode, execute, memory and writeback over several clocks, so one ALU and one memory port are shared across the instruction.
// Decodes op/funct and drives all datapath selects and write enables each cycle.
// Stalls on a memory ready handshake.
// Traps illegal opcodes and memory timeouts into a sticky halt state.
// PARAMETERS
// MAX_WAIT  16  max cycles a memory access may wait for mem_ready; 0 = wait forever
// PORTS
// clk          in   1  clock
// reset        in   1  synchronous, active-high reset
// op           in   6  instr[31:26] from instruction register
// funct        in   6  instr[5:0]
// zero         in   1  ALU zero flag
// mem_ready    in   1  memory completes current access this cycle
// pcen         out  1  PC register enable = pcwrite | (branch & zero)
// iord         out  1  memory address select: 0 = PC, 1 = ALUOut
// memwrite     out  1  memory write strobe
// irwrite      out  1  instruction register load
// regwrite     out  1  register file write enable
// regdst       out  1  0 = rt, 1 = rd
// memtoreg     out  1  0 = ALUOut, 1 = data register
// alusrca      out  1  0 = PC, 1 = register A
// alusrcb      out  2  00 = B, 01 = constant 1, 10 = signimm, 11 = signimm (word addressed, no shift)
// pcsrc        out  2  00 = ALU result, 01 = ALUOut, 10 = jump target {pc[31:26], instr[25:0]}
// alucontrol   out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
// halted       out  1  sticky: FSM is in HALT
// err_code     out  2  00 none, 01 illegal op/funct, 10 memory timeout; valid while halted
// state_dbg    out  4  current state encoding
// BEHAVIOUR
// - Chip-level timing
//   - All outputs are Moore decodes of the state, except pcen, which uses zero.
//   - pcen, irwrite, memwrite and regwrite are forced 0 during any cycle with reset=1.
//   - Reset forces: state=FETCH(0), err_code=00, wait counter=0. Takes priority over every transition, including HALT and mid-access.
// - States (encoding)
//   - FETCH(0): iord=0, alusrca=0, alusrcb=01, alu add, pcsrc=00. irwrite and pcwrite only in the cycle mem_ready=1, then -> DECODE; else stay.
//   - DECODE(1): alusrca=0, alusrcb=11, add (branch target into ALUOut).
//     - lw/sw -> MEMADR; R-type -> EXEC; beq -> BRANCH; addi -> ADDIEX; j -> JUMP.
//     - Other op, or R-type with undefined funct -> HALT, err 01.
//   - MEMADR(2): alusrca=1, alusrcb=10, add. lw -> MEMRD; sw -> MEMWR.
//   - MEMRD(3): iord=1. Stay until mem_ready, then -> MEMWB.
//   - MEMWB(4): regdst=0, memtoreg=1, regwrite=1 -> FETCH.
//   - MEMWR(5): iord=1, memwrite=1 held every cycle until mem_ready, then -> FETCH.
//   - EXEC(6): alusrca=1, alusrcb=00, alucontrol from funct:
//     - add 100000 -> 010; sub 100010 -> 110; and 100100 -> 000; or 100101 -> 001; slt 101010 -> 111.
//     - -> ALUWB.
//   - ALUWB(7): regdst=1, memtoreg=0, regwrite=1 -> FETCH.
//   - BRANCH(8): alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1. pcen = zero -> FETCH.
//   - ADDIEX(9): alusrca=1, alusrcb=10, add -> ADDIWB.
//   - ADDIWB(10): regdst=0, memtoreg=0, regwrite=1 -> FETCH.
//   - JUMP(11): pcsrc=10, pcwrite=1 -> FETCH.
//   - HALT(12): all enables 0, halted=1; stays until reset.
//   - Encodings 13-15: -> HALT, err 01.
// - Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
// - Wait counter
//   - Clears on entry to FETCH/MEMRD/MEMWR and increments each cycle spent there without mem_ready.
//   - If MAX_WAIT!=0 and the count reaches MAX_WAIT with mem_ready=0 -> HALT, err 10.
//   - If mem_ready arrives in that same cycle, it wins.
// - Latency with zero-wait memory: R/addi/sw 4 cycles, lw 5, beq/j 3. Each memory wait cycle adds 1.
// - Unused select outputs are 0 in states that do not name them.
// TESTING
// - Reset, then add (op 0, funct 100000), mem_ready=1 -> states 0,1,6,7,0; irwrite@0; regwrite=1, regdst=1 @7; 4 cycles.
// - lw, mem_ready low 2 cycles in MEMRD -> 0,1,2,3,3,3,4,0; iord=1 held 3 cycles; memtoreg=1, regwrite @4.
// - beq: zero=1 -> pcen=1, pcsrc=01 in state 8. Repeat with zero=0 -> pcen=0, next state FETCH.
// - op=111111 at DECODE -> HALT next cycle, halted=1, err_code=01, all enables 0 for 20 cycles. Reset -> FETCH.
// - sw, MAX_WAIT=4, mem_ready never asserted -> memwrite high 4 cycles, then HALT with err_code=10.
// - Reset asserted mid-MEMWR -> memwrite=0 that cycle; next state FETCH, err_code=00.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Bundle between the multicycle MIPS control FSM and its datapath.
//   master : the controller; reads op/funct/zero/mem_ready, drives every select,
//            enable and status output.
//   slave  : the datapath side; drives the decode/status inputs, reads the controls.
// Signals:
//   op[5:0], funct[5:0]  instruction fields from the instruction register
//   zero                 ALU zero flag
//   mem_ready            memory completes the current access this cycle
//   pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca
//   alusrcb[1:0], pcsrc[1:0], alucontrol[2:0]   datapath controls
//   halted, err_code[1:0], state_dbg[3:0]       status / debug
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       halted;
    logic [1:0] err_code;
    logic [3:0] state_dbg;

    modport master (
        input  op, funct, zero, mem_ready,
        output pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
               alusrcb, pcsrc, alucontrol, halted, err_code, state_dbg
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
               alusrcb, pcsrc, alucontrol, halted, err_code, state_dbg
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control FSM for the 32-bit MIPS datapath. Sequences fetch, decode,
// execute, memory and writeback so one ALU and one memory port are shared across
// an instruction. Stalls on mem_ready and traps illegal opcodes/functs and memory
// timeouts into a sticky HALT state that only reset leaves.
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    mips_multicycle_ctrl_if.master (decode inputs, datapath controls, status)
// Parameter:
//   MAX_WAIT  cycles a memory access may wait for mem_ready before trapping; 0 = forever
module mips_multicycle_ctrl #(
    parameter int MAX_WAIT = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    mips_multicycle_ctrl_if.master        bus
);
    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11,
        HALT   = 4'd12
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      err_q, err_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic            timeout;
    logic            pcwrite, branch, irwrite_c, memwrite_c, regwrite_c;
    logic            iord_c, regdst_c, memtoreg_c, alusrca_c, halted_c;
    logic [1:0]      alusrcb_c, pcsrc_c;
    logic [2:0]      alucontrol_c;

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
               (f == 6'b100101) || (f == 6'b101010);
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // The access traps in the cycle the count would reach MAX_WAIT; a mem_ready
    // in that same cycle is checked first and wins.
    assign timeout = (MAX_WAIT != 0) && ((int'(wait_q) + 1) >= MAX_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            err_q   <= ERR_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        irwrite_c    = 1'b0;
        memwrite_c   = 1'b0;
        regwrite_c   = 1'b0;
        iord_c       = 1'b0;
        regdst_c     = 1'b0;
        memtoreg_c   = 1'b0;
        alusrca_c    = 1'b0;
        alusrcb_c    = 2'b00;
        pcsrc_c      = 2'b00;
        alucontrol_c = 3'b000;
        halted_c     = 1'b0;
        case (state_q)
            FETCH: begin
                alusrcb_c    = 2'b01;
                alucontrol_c = 3'b010;
                if (bus.mem_ready) begin
                    irwrite_c = 1'b1;
                    pcwrite   = 1'b1;
                    state_d   = DECODE;
                end else if (timeout) begin
                    state_d = HALT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            DECODE: begin
                // Branch target is computed here while the IR decodes.
                alusrcb_c    = 2'b11;
                alucontrol_c = 3'b010;
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    OP_R: begin
                        if (funct_legal(bus.funct)) begin
                            state_d = EXEC;
                        end else begin
                            state_d = HALT;
                            err_d   = ERR_ILLEGAL;
                        end
                    end
                    default: begin
                        state_d = HALT;
                        err_d   = ERR_ILLEGAL;
                    end
                endcase
            end
            MEMADR: begin
                alusrca_c    = 1'b1;
                alusrcb_c    = 2'b10;
                alucontrol_c = 3'b010;
                state_d      = (bus.op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord_c = 1'b1;
                if (bus.mem_ready) begin
                    state_d = MEMWB;
                end else if (timeout) begin
                    state_d = HALT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            MEMWB: begin
                memtoreg_c = 1'b1;
                regwrite_c = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                iord_c     = 1'b1;
                memwrite_c = 1'b1;
                if (bus.mem_ready) begin
                    state_d = FETCH;
                end else if (timeout) begin
                    state_d = HALT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            EXEC: begin
                alusrca_c    = 1'b1;
                alucontrol_c = funct_alu(bus.funct);
                state_d      = ALUWB;
            end
            ALUWB: begin
                regdst_c   = 1'b1;
                regwrite_c = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alusrca_c    = 1'b1;
                alucontrol_c = 3'b110;
                pcsrc_c      = 2'b01;
                branch       = 1'b1;
                state_d      = FETCH;
            end
            ADDIEX: begin
                alusrca_c    = 1'b1;
                alusrcb_c    = 2'b10;
                alucontrol_c = 3'b010;
                state_d      = ADDIWB;
            end
            ADDIWB: begin
                regwrite_c = 1'b1;
                state_d    = FETCH;
            end
            JUMP: begin
                pcsrc_c = 2'b10;
                pcwrite = 1'b1;
                state_d = FETCH;
            end
            HALT: begin
                halted_c = 1'b1;
            end
            default: begin
                state_d = HALT;
                err_d   = ERR_ILLEGAL;
            end
        endcase
    end

    // Wait counter restarts on every state change, so each fetch/read/write
    // access gets its own budget.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (((state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR)) &&
                     !bus.mem_ready) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Strobes are gated by reset so nothing is written while reset is held,
    // whatever state the FSM happens to be in.
    assign bus.pcen       = ~reset & (pcwrite | (branch & bus.zero));
    assign bus.irwrite    = ~reset & irwrite_c;
    assign bus.memwrite   = ~reset & memwrite_c;
    assign bus.regwrite   = ~reset & regwrite_c;
    assign bus.iord       = iord_c;
    assign bus.regdst     = regdst_c;
    assign bus.memtoreg   = memtoreg_c;
    assign bus.alusrca    = alusrca_c;
    assign bus.alusrcb    = alusrcb_c;
    assign bus.pcsrc      = pcsrc_c;
    assign bus.alucontrol = alucontrol_c;
    assign bus.halted     = halted_c;
    assign bus.err_code   = err_q;
    assign bus.state_dbg  = state_q;
endmodule
